// File: rtl/htg_ad9213_mmcm_ctrl.sv
// Reset/lock sequencer for the AD9213 sample-clock MMCM, clocked from the free-running system clock.
// Optional feature: define HTG_AD9213_MMCM_CTRL_UNLOCK_CNT_EN to build the saturating unlock counter.
module htg_ad9213_mmcm_ctrl #(
  parameter int unsigned RST_CYCLES   = 16,
  parameter int unsigned LOCK_TIMEOUT = 65536,
  parameter int unsigned LOCK_STABLE  = 1024,
  parameter int unsigned MAX_RETRIES  = 7
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic        restart,
  input  logic        locked_in,
  output logic        mmcm_rst,
  output logic        mmcm_pwrdwn,
  output logic        ready,
  output logic        fault,
  output logic [3:0]  retry_count,
  output logic [15:0] unlock_count
);

  localparam logic [16:0] RstLast     = 17'(RST_CYCLES - 1);
  localparam logic [16:0] TimeoutLast = 17'(LOCK_TIMEOUT - 1);
  localparam logic [16:0] StableLast  = 17'(LOCK_STABLE - 1);
  localparam logic [3:0]  MaxRetry    = 4'(MAX_RETRIES);

  typedef enum logic [2:0] {
    StIdle,
    StReset,
    StWaitLock,
    StStable,
    StRun,
    StFault
  } state_e;

  state_e      state_q, state_d;
  logic [1:0]  sync_q;
  logic        lk;
  logic [16:0] timer_q, timer_d;
  logic        tmr_clr;
  logic        fail;
  logic [3:0]  retry_q, retry_d;
  logic        unlock_inc;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= 2'b00;
    end else begin
      sync_q <= {sync_q[0], locked_in};
    end
  end

  assign lk = sync_q[1];

  always_comb begin
    state_d    = state_q;
    tmr_clr    = 1'b0;
    fail       = 1'b0;
    retry_d    = retry_q;
    unlock_inc = 1'b0;
    if (!enable) begin
      if (state_q != StIdle) begin
        state_d = StIdle;
        tmr_clr = 1'b1;
      end
    end else if (restart && (state_q != StIdle)) begin
      state_d = StReset;
      tmr_clr = 1'b1;
      retry_d = 4'd0;
    end else begin
      case (state_q)
        StIdle: begin
          state_d = StReset;
          tmr_clr = 1'b1;
          retry_d = 4'd0;
        end
        StReset: begin
          if (timer_q == RstLast) begin
            state_d = StWaitLock;
            tmr_clr = 1'b1;
          end
        end
        StWaitLock: begin
          if (lk) begin
            state_d = StStable;
            tmr_clr = 1'b1;
          end else if (timer_q == TimeoutLast) begin
            fail = 1'b1;
          end
        end
        StStable: begin
          // The timer doubles as the consecutive-lock counter; any drop aborts the attempt.
          if (!lk) begin
            fail = 1'b1;
          end else if (timer_q == StableLast) begin
            state_d = StRun;
            tmr_clr = 1'b1;
          end
        end
        StRun: begin
          if (!lk) begin
            unlock_inc = 1'b1;
            retry_d    = 4'd0;
            state_d    = StReset;
            tmr_clr    = 1'b1;
          end
        end
        StFault: ;
        default: begin
          state_d = StIdle;
          tmr_clr = 1'b1;
        end
      endcase
      if (fail) begin
        tmr_clr = 1'b1;
        if (retry_q == MaxRetry) begin
          state_d = StFault;
        end else begin
          retry_d = retry_q + 4'd1;
          state_d = StReset;
        end
      end
    end
  end

  assign timer_d = tmr_clr ? 17'd0 : timer_q + 17'd1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      timer_q <= 17'd0;
      retry_q <= 4'd0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      retry_q <= retry_d;
    end
  end

  // Outputs decode the registered state, so they trail each transition by one cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mmcm_rst    <= 1'b1;
      mmcm_pwrdwn <= 1'b1;
      ready       <= 1'b0;
      fault       <= 1'b0;
    end else begin
      mmcm_rst    <= (state_q == StIdle) || (state_q == StReset) || (state_q == StFault);
      mmcm_pwrdwn <= (state_q == StIdle);
      ready       <= (state_q == StRun);
      fault       <= (state_q == StFault);
    end
  end

  assign retry_count = retry_q;

`ifdef HTG_AD9213_MMCM_CTRL_UNLOCK_CNT_EN
  logic [15:0] unlock_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      unlock_q <= 16'd0;
    end else if (unlock_inc && (unlock_q != 16'hFFFF)) begin
      unlock_q <= unlock_q + 16'd1;
    end
  end

  assign unlock_count = unlock_q;
`else
  logic unused_unlock_inc;
  assign unused_unlock_inc = unlock_inc;
  assign unlock_count      = 16'd0;
`endif

endmodule
